// File: rtl/rx_fifo_blk.sv
// UART receiver (2-flop synchroniser, start/data/parity/stop FSM) feeding a first-word-fall-through FIFO.
// Define RX_PARITY_EN to build the PARITY state and parity_err logic; otherwise frames carry no parity bit.
module rx_fifo_blk #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 100_000,
  parameter int PARITY_MODE = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          read,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          out,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = $clog2(DIV) + 1;
  localparam logic [BW-1:0] L_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0] L_HALF = BW'(DIV / 2 - 1);
  localparam logic [3:0]    L_NBM1 = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] L_FULL = CW'(FIFO_DEPTH);
`ifdef RX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != 0);
`else
  localparam bit PAR_ON = 1'b0 && (PARITY_MODE != 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef RX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  logic                 r_sync1, r_sync2, r_prev;
  logic                 w_rx, w_fall;
  state_t               r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 r_overflow;
`ifdef RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
  logic                 w_par_exp;
`endif

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [CW-1:0]        r_count;
  logic                 w_pop, w_full, w_wr;

  // Stage: input synchroniser and falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rx   = r_sync2;
  assign w_fall = r_prev & ~r_sync2;

`ifdef RX_PARITY_EN
  assign w_par_exp = (PARITY_MODE == 2) ? ~(^r_shift) : (^r_shift);
`endif

  // Stage: receiver FSM; errors set after clr_err so a same-cycle set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bitcnt    <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_push <= 1'b0;
      if (clr_err) begin
        r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
      case (r_state)
        S_IDLE: begin
          r_baud   <= '0;
          r_bitcnt <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (r_baud == L_HALF) begin
            r_baud  <= '0;
`ifdef RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
            r_state <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (r_baud == L_LAST) begin
            r_baud   <= '0;
            r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == L_NBM1) begin
`ifdef RX_PARITY_EN
              r_state <= PAR_ON ? S_PARITY : S_STOP;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        S_PARITY: begin
          if (r_baud == L_LAST) begin
            r_baud    <= '0;
            r_par_bad <= (w_rx != w_par_exp);
            r_state   <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_baud == L_LAST) begin
            r_baud <= '0;
            if (!w_rx) begin
              r_frame_err <= 1'b1;
              r_state     <= S_RECOVER;
            end
`ifdef RX_PARITY_EN
            else if (r_par_bad) begin
              r_parity_err <= 1'b1;
              r_state      <= S_IDLE;
            end
`endif
            else begin
              r_push  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_RECOVER: begin
          // A held-low break must not be mistaken for a new start bit
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage: FIFO; when full, a simultaneous pop frees the slot being written
  assign w_pop  = read && (r_count != '0);
  assign w_full = (r_count == L_FULL);
  assign w_wr   = r_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (clr_err) r_overflow <= 1'b0;
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign ready     = (r_count != '0);
  assign count     = r_count;
  assign out       = ready ? r_mem[r_rd] : '0;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
`ifdef RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = PAR_ON;
`endif

endmodule

// File: tb/tb_rx_fifo_blk.sv
// Scoreboard bench for rx_fifo_blk: a queue model of the FIFO plus sticky-flag model; a monitor checks every pop.
module tb_rx_fifo_blk;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
  localparam int GOOD = 1;
`else
  localparam int GOOD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       read = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] out;
  logic       ready;
  logic [2:0] count;
  logic       frame_err, parity_err, overflow;

  always #5 clk = ~clk;

  rx_fifo_blk #(
    .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .CLK_FREQ(100_000_000),
    .BAUD(10_000_000), .PARITY_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .read(read), .clr_err(clr_err),
    .out(out), .ready(ready), .count(count),
    .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
  );

  logic [7:0] exp_q[$];
  bit exp_ferr = 0, exp_perr = 0, exp_ovf = 0;
  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic check_state(input string tag);
    check({tag, " count"}, count, exp_q.size());
    check({tag, " ready"}, ready, exp_q.size() != 0);
    check({tag, " frame_err"}, frame_err, exp_ferr);
    check({tag, " parity_err"}, parity_err, exp_perr);
    check({tag, " overflow"}, overflow, exp_ovf);
  endtask

  // Monitor: every accepted pop must present the oldest expected byte
  always @(negedge clk) begin
    if (!rst && read && ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL pop: got %0h want none", out);
      end else begin
        check("pop data", out, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pmode: 0 no parity bit, 1 correct even parity, 2 wrong parity
  task automatic send(input logic [7:0] d, input logic stop_b, input int pmode, input bit rd_at_push);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (DIV) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(posedge clk); #1;
    end
    if (pmode != 0) begin
      rx = (^d) ^ (pmode == 2);
      repeat (DIV) @(posedge clk); #1;
    end
    rx = stop_b;
    repeat (DIV - 2) @(posedge clk); #1;
    if (rd_at_push) read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
    if (!stop_b) exp_ferr = 1;
    else if (pmode == 2) exp_perr = 1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1;
  endtask

  task automatic do_read();
    @(posedge clk); #1;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    exp_ferr = 0; exp_perr = 0; exp_ovf = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset out", out, 0);
    check_state("reset");

    send(8'hA5, 1'b1, GOOD, 1'b0);
    check_state("A5 rx");
    idle(3);
    send(8'h3C, 1'b1, GOOD, 1'b0);
    check_state("3C rx");
    check("head A5", out, 8'hA5);
    do_read();
    check_state("after read1");
    do_read();
    check_state("after read2");
    do_read();
    check_state("read empty");

    for (int i = 1; i <= 6; i++) send(8'(i), 1'b1, GOOD, 1'b0);
    check_state("overflow");
    for (int i = 0; i < 4; i++) do_read();
    check_state("drained");
    pulse_clr();
    check_state("clr ovf");

    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1, GOOD, 1'b0);
    check_state("full");
    send(8'h15, 1'b1, GOOD, 1'b1);
    check_state("full push+pop");
    check("head after push+pop", out, 8'h12);
    for (int i = 0; i < 4; i++) do_read();
    check_state("drained2");

    send(8'h55, 1'b0, GOOD, 1'b0);
    idle(30);
    check_state("break");
    rx = 1'b1;
    idle(5);
    send(8'h12, 1'b1, GOOD, 1'b0);
    check_state("after break");
    do_read();
    pulse_clr();
    check_state("clr ferr");

`ifdef RX_PARITY_EN
    send(8'h07, 1'b1, 2, 1'b0);
    check_state("bad parity");
    pulse_clr();
    check_state("clr perr");
    send(8'h07, 1'b1, 1, 1'b0);
    check_state("good parity");
    do_read();
`endif

    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3) @(posedge clk); #1;
    rx = 1'b1;
    idle(30);
    check_state("glitch");

    @(posedge clk); #1;
    rx = 1'b0;
    repeat (DIV) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (DIV) @(posedge clk); #1;
    end
    rx = 1'b1;
    repeat (DIV / 2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_ferr = 0; exp_perr = 0; exp_ovf = 0;
    idle(30);
    check_state("mid-frame rst");
    send(8'h9B, 1'b1, GOOD, 1'b0);
    check_state("after rst frame");
    do_read();

    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 7);
      d = 8'($urandom_range(0, 255));
      if (r < 2 && exp_q.size() > 0) do_read();
      else if (r == 2) begin
        send(d, 1'b0, GOOD, 1'b0);
        idle(12);
        rx = 1'b1;
        idle(3);
      end else if (r == 3) pulse_clr();
      else send(d, 1'b1, GOOD, (exp_q.size() > 0) && ($urandom_range(0, 1) == 1));
      check_state($sformatf("rand%0d", it));
    end

    while (exp_q.size() > 0) do_read();
    check_state("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
